// File: rtl/program_loader.sv
// program_loader: boot-time UART image loader for the stack processor.
// Receives an 8N1 byte stream and parses frames of the form
// A5, LEN_HI, LEN_LO, LEN big-endian words, CHK. Each word is written into
// the instruction ROM. The core is held in reset until an image with a
// matching checksum has been accepted. Any later A5 header re-arms the loader.
module program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4096,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        rom_wren,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam int CPB_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CPB_W-1:0] BIT_LAST  = CPB_W'(CLKS_PER_BIT - 1);
  localparam logic [CPB_W-1:0] HALF_LAST = CPB_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]      DEPTH_L   = 17'(DEPTH);
  localparam logic [7:0]       HDR_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_HDR,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    FAIL
  } frame_state_t;

  // Running 8-bit checksum; wraps modulo 256.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // rx synchronizer and edge history
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  // UART receiver
  rx_state_t        rx_state_q;
  logic [CPB_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  // frame parser
  frame_state_t     fr_state_q;
  logic [15:0]      len_q;
  logic [15:0]      index_q;
  logic [7:0]       hi_q;
  logic [7:0]       chk_q;
  logic [TO_W-1:0]  idle_cnt_q;
  logic [15:0]      rom_addr_q;
  logic [15:0]      rom_data_q;
  logic             rom_wren_q;
  logic             cpu_reset_q;
  logic             load_done_q;
  logic             load_error_q;
  logic [15:0]      word_count_q;

  logic [15:0]      len_next_s;
  logic             len_too_big_s;
  logic             in_active_s;

  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_wren   = rom_wren_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = word_count_q;

  assign len_next_s = {len_q[15:8], byte_q};

  // Length check against ROM capacity, evaluated on the LEN_LO byte.
  always_comb begin
    len_too_big_s = 1'b0;
    if ({1'b0, len_next_s} > DEPTH_L) begin
      len_too_big_s = 1'b1;
    end else begin
      len_too_big_s = 1'b0;
    end
  end

  // States in which a frame is in flight and the inter-byte timeout runs.
  always_comb begin
    in_active_s = 1'b0;
    case (fr_state_q)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: in_active_s = 1'b1;
      default:                                 in_active_s = 1'b0;
    endcase
  end

  // Two-flop synchronizer for rx plus one history flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // 8N1 receiver: mid-bit sampling, glitch rejection on the start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= 3'd0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            // A line already back high at mid start bit was only a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CPB_W'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CPB_W'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CPB_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Frame parser: header, length, words, checksum; drives ROM port and core reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fr_state_q   <= WAIT_HDR;
      len_q        <= 16'h0000;
      index_q      <= 16'h0000;
      hi_q         <= 8'h00;
      chk_q        <= 8'h00;
      idle_cnt_q   <= '0;
      rom_addr_q   <= 16'h0000;
      rom_data_q   <= 16'h0000;
      rom_wren_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      word_count_q <= 16'h0000;
    end else begin
      rom_wren_q <= 1'b0;
      if (byte_valid_q) begin
        // idle_cnt_q counts cycles elapsed since the last received byte.
        idle_cnt_q <= TO_W'(1);
        case (fr_state_q)
          WAIT_HDR, DONE, FAIL: begin
            if (byte_q == HDR_BYTE) begin
              fr_state_q   <= LEN_HI;
              cpu_reset_q  <= 1'b1;
              load_done_q  <= 1'b0;
              load_error_q <= 1'b0;
              chk_q        <= 8'h00;
              index_q      <= 16'h0000;
            end
          end
          LEN_HI: begin
            len_q      <= {byte_q, 8'h00};
            chk_q      <= chk_add(chk_q, byte_q);
            fr_state_q <= LEN_LO;
          end
          LEN_LO: begin
            len_q <= len_next_s;
            chk_q <= chk_add(chk_q, byte_q);
            if (len_too_big_s) begin
              fr_state_q   <= FAIL;
              load_error_q <= 1'b1;
              cpu_reset_q  <= 1'b1;
              load_done_q  <= 1'b0;
            end else if (len_next_s == 16'h0000) begin
              fr_state_q <= CHECK;
            end else begin
              fr_state_q <= DATA_HI;
            end
          end
          DATA_HI: begin
            hi_q       <= byte_q;
            chk_q      <= chk_add(chk_q, byte_q);
            fr_state_q <= DATA_LO;
          end
          DATA_LO: begin
            rom_wren_q <= 1'b1;
            rom_addr_q <= index_q;
            rom_data_q <= {hi_q, byte_q};
            index_q    <= index_q + 16'd1;
            chk_q      <= chk_add(chk_q, byte_q);
            fr_state_q <= ((index_q + 16'd1) == len_q) ? CHECK : DATA_HI;
          end
          CHECK: begin
            if (byte_q == chk_q) begin
              fr_state_q   <= DONE;
              word_count_q <= len_q;
              cpu_reset_q  <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              fr_state_q   <= FAIL;
              load_error_q <= 1'b1;
              cpu_reset_q  <= 1'b1;
              load_done_q  <= 1'b0;
            end
          end
          default: fr_state_q <= WAIT_HDR;
        endcase
      end else if (frame_err_q && in_active_s) begin
        fr_state_q   <= FAIL;
        load_error_q <= 1'b1;
        cpu_reset_q  <= 1'b1;
        load_done_q  <= 1'b0;
        idle_cnt_q   <= '0;
      end else if (in_active_s) begin
        if (idle_cnt_q == TO_LAST) begin
          fr_state_q   <= FAIL;
          load_error_q <= 1'b1;
          cpu_reset_q  <= 1'b1;
          load_done_q  <= 1'b0;
          idle_cnt_q   <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_program_loader;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int TOUT  = 1000;

  logic        clock;
  logic        reset;
  logic        rx;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_wren;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH),
    .TIMEOUT_CLKS(TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rom_wren(rom_wren),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .load_error(load_error),
    .word_count(word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr_cyc = 0;
  bit prev_wren = 1'b0;
  bit b2b_seen  = 1'b0;

  logic [7:0]  frm[$];
  logic [31:0] exp_wr[$];
  logic [31:0] act_wr[$];
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic        exp_cpu  = 1'b1;
  logic [15:0] exp_wc   = 16'h0000;

  always @(posedge clock) cyc <= cyc + 1;

  // ROM write-port monitor
  always @(negedge clock) begin
    if (rom_wren) begin
      act_wr.push_back({rom_addr, rom_data});
      last_wr_cyc = cyc;
      if (prev_wren) b2b_seen = 1'b1;
    end
    prev_wren = rom_wren;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".rom_addr"}, 32'(rom_addr), 32'h0);
    check_eq({tag, ".rom_data"}, 32'(rom_data), 32'h0);
    check_eq({tag, ".rom_wren"}, 32'(rom_wren), 32'h0);
    check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'h1);
    check_eq({tag, ".load_done"}, 32'(load_done), 32'h0);
    check_eq({tag, ".load_error"}, 32'(load_error), 32'h0);
    check_eq({tag, ".word_count"}, 32'(word_count), 32'h0);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".wr_count"}, 32'(act_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      check_eq($sformatf("%s.wr%0d", tag, i), act_wr[i], exp_wr[i]);
    if (exp_wr.size() > 0)
      check_eq({tag, ".rom_hold"}, {rom_addr, rom_data}, exp_wr[$]);
    check_eq({tag, ".load_done"}, 32'(load_done), 32'(exp_done));
    check_eq({tag, ".load_error"}, 32'(load_error), 32'(exp_err));
    check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(exp_cpu));
    check_eq({tag, ".word_count"}, 32'(word_count), 32'(exp_wc));
    check_eq({tag, ".wren_gap"}, 32'(b2b_seen), 32'h0);
    act_wr.delete();
    exp_wr.delete();
    b2b_seen = 1'b0;
  endtask

  // Frame-level reference: locate the header, read LEN, list the words,
  // sum the bytes and decide the outcome.
  task automatic model_frame();
    int h;
    int len;
    int sum;
    h = -1;
    for (int i = 0; i < frm.size(); i++)
      if (h < 0 && frm[i] == 8'hA5) h = i;
    if (h < 0 || frm.size() < h + 3) return;
    len = int'(frm[h+1]) * 256 + int'(frm[h+2]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_cpu  = 1'b1;
    if (len > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    sum = int'(frm[h+1]) + int'(frm[h+2]);
    for (int w = 0; w < len; w++) begin
      exp_wr.push_back({16'(w), frm[h+3+2*w], frm[h+4+2*w]});
      sum += int'(frm[h+3+2*w]) + int'(frm[h+4+2*w]);
    end
    if (int'(frm[h+3+2*len]) == sum % 256) begin
      exp_done = 1'b1;
      exp_cpu  = 1'b0;
      exp_wc   = 16'(len);
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clock);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
    repeat (20) @(negedge clock);
  endtask

  task automatic run_frame(input string tag);
    model_frame();
    send_frame();
    compare_all(tag);
  endtask

  initial begin
    int len;
    int sum;
    int waited;
    logic [7:0] b;
    logic [7:0] part;

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);

    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    run_frame("two_words");

    frm = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55};
    run_frame("bad_chk");

    frm = '{8'h3C, 8'h7E, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("junk_empty");

    frm = '{8'hA5, 8'h00, 8'h04};
    sum = 4;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      sum += int'(b);
    end
    frm.push_back(8'(sum % 256));
    run_frame("full_depth");

    frm = '{8'hA5, 8'h00, 8'h05};
    run_frame("oversize");

    // one-cycle start glitch, then a real frame straight after it
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (6) @(negedge clock);
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("after_glitch");

    // stop bit low inside a frame
    frm = '{8'hA5, 8'h00, 8'h01};
    send_frame();
    send_byte(8'h77, 1'b0);
    repeat (20) @(negedge clock);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_cpu  = 1'b1;
    compare_all("framing");

    // inter-byte timeout, measured from the write that follows the last byte
    frm = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22};
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
    waited = 0;
    while (!load_error && waited < 3 * TOUT) begin
      @(negedge clock);
      waited++;
    end
    check_eq("timeout.fired", 32'(load_error), 32'h1);
    check_eq("timeout.delay", 32'(cyc - last_wr_cyc), 32'(TOUT - 1));
    exp_wr.push_back(32'h0000_1122);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_cpu  = 1'b1;
    repeat (5) @(negedge clock);
    compare_all("timeout");

    frm = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
    run_frame("pre_reload");

    // reload after success: cpu_reset must come back as soon as the header lands
    frm = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAE};
    model_frame();
    send_byte(frm[0], 1'b1);
    repeat (20) @(negedge clock);
    check_eq("reload.cpu_reset_hdr", 32'(cpu_reset), 32'h1);
    check_eq("reload.load_done_hdr", 32'(load_done), 32'h0);
    for (int i = 1; i < frm.size(); i++) send_byte(frm[i], 1'b1);
    repeat (20) @(negedge clock);
    compare_all("reload");

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      frm.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        frm.push_back(b);
      end
      frm.push_back(8'hA5);
      len = int'($urandom_range(0, 5));
      if (len == 5 && $urandom_range(0, 1) == 1) begin
        frm.push_back(8'($urandom_range(1, 255)));
        frm.push_back(8'($urandom_range(0, 255)));
      end else begin
        frm.push_back(8'h00);
        frm.push_back(8'(len));
        if (len <= DEPTH) begin
          sum = len;
          for (int i = 0; i < 2 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            frm.push_back(b);
            sum += int'(b);
          end
          b = 8'(sum % 256);
          if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
          frm.push_back(b);
        end
      end
      run_frame($sformatf("rand%0d", n));
    end

    // reset in the middle of the low byte of a word
    frm = '{8'hA5, 8'h00, 8'h01, 8'hBE};
    send_frame();
    part = 8'hEF;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("midword_reset");
    repeat (200) @(negedge clock);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_cpu  = 1'b1;
    exp_wc   = 16'h0000;
    compare_all("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
